// File: rtl/bomberman_pkg.sv
// bomberman_pkg: arena codes, coordinate width and blast-engine FSM states
package bomberman_pkg;
    localparam int COORD_W = 4;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HARD  = 2'd1;
    localparam logic [1:0] SOFT  = 2'd2;
    localparam logic [1:0] BOMB  = 2'd3;
    typedef enum logic [2:0] {IDLE, DECR, SELECT, CENTER, RD, EVAL, FREE, DAMAGE} engineState;
endpackage

// File: rtl/bomb_slots.sv
// bomb_slots: live-bomb table with fuse counters, lowest-free allocation and lowest-expired lookup
module bomb_slots
    import bomberman_pkg::*;
#(
    parameter int MAX_BOMBS = 4,
    parameter int FUSE = 3,
    localparam int IW = MAX_BOMBS > 1 ? $clog2(MAX_BOMBS) : 1,
    localparam int FW = $clog2(FUSE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic allocEn,
    input  logic decAll,
    input  logic forceEn,
    input  logic freeEn,
    input  logic [IW-1:0] freeIdx,
    input  logic [COORD_W-1:0] matchX,
    input  logic [COORD_W-1:0] matchY,
    output logic [IW-1:0] expIdx,
    output logic anyExp,
    output logic freeAvail,
    output logic occMatch,
    output logic [COORD_W-1:0] expX,
    output logic [COORD_W-1:0] expY
);
    logic [MAX_BOMBS-1:0] valid;
    logic [MAX_BOMBS-1:0] hit;
    logic [COORD_W-1:0] slotX [MAX_BOMBS];
    logic [COORD_W-1:0] slotY [MAX_BOMBS];
    logic [FW-1:0] fuse [MAX_BOMBS];
    logic [IW-1:0] freeLow;

    // Descending scan so the lowest index wins both searches
    always_comb begin
        hit = '0;
        freeLow = '0;
        freeAvail = 1'b0;
        expIdx = '0;
        anyExp = 1'b0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            hit[i] = valid[i] && slotX[i] == matchX && slotY[i] == matchY;
            if (!valid[i]) begin
                freeLow = IW'(i);
                freeAvail = 1'b1;
            end
            if (valid[i] && fuse[i] == '0) begin
                expIdx = IW'(i);
                anyExp = 1'b1;
            end
        end
    end

    assign occMatch = |hit;
    assign expX = slotX[expIdx];
    assign expY = slotY[expIdx];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                slotX[i] <= '0;
                slotY[i] <= '0;
                fuse[i] <= '0;
            end
        end else
            for (int i = 0; i < MAX_BOMBS; i++) begin
                if (allocEn && freeLow == IW'(i)) begin
                    valid[i] <= 1'b1;
                    slotX[i] <= matchX;
                    slotY[i] <= matchY;
                    fuse[i] <= FW'(FUSE);
                end
                if (decAll && valid[i] && fuse[i] != '0) fuse[i] <= fuse[i] - 1'b1;
                if (forceEn && hit[i]) fuse[i] <= '0;
                if (freeEn && freeIdx == IW'(i)) valid[i] <= 1'b0;
            end
endmodule

// File: rtl/blast_engine.sv
// blast_engine: owns live bombs, counts fuses on the bomb tick and resolves
// cross-shaped blasts over the arena, chaining bombs and damaging players.
module blast_engine
    import bomberman_pkg::*;
#(
    parameter int GRID = 10,
    parameter int MAX_BOMBS = 4,
    parameter int FUSE = 3,
    parameter int RANGE = 2,
    parameter int HEALTH_INIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bomb_tick,
    input  logic place_valid,
    input  logic [COORD_W-1:0] place_x,
    input  logic [COORD_W-1:0] place_y,
    output logic place_ready,
    input  logic [COORD_W-1:0] pos_a_x,
    input  logic [COORD_W-1:0] pos_a_y,
    input  logic [COORD_W-1:0] pos_b_x,
    input  logic [COORD_W-1:0] pos_b_y,
    output logic [COORD_W-1:0] arena_rd_x,
    output logic [COORD_W-1:0] arena_rd_y,
    input  logic [1:0] arena_rd_data,
    output logic arena_wr_en,
    output logic [COORD_W-1:0] arena_wr_x,
    output logic [COORD_W-1:0] arena_wr_y,
    output logic [1:0] arena_wr_data,
    output logic [1:0] health_a,
    output logic [1:0] health_b,
    output logic game_over,
    output logic busy
);
    localparam int IW = MAX_BOMBS > 1 ? $clog2(MAX_BOMBS) : 1;
    localparam int SW = $clog2(RANGE + 1);
    localparam logic [SW-1:0] RANGE_S = SW'(RANGE);
    localparam logic signed [COORD_W+1:0] GRID_S = (COORD_W + 2)'(GRID);

    engineState state;
    logic pending, hitA, hitB, hitNowA, hitNowB;
    logic inGrid, accept, allocEn, occMatch, freeAvail, anyExp;
    logic [1:0] dir;
    logic [SW-1:0] step;
    logic [IW-1:0] selIdx, expIdx;
    logic [COORD_W-1:0] cx, cy, rdX, rdY, expX, expY, chkX, chkY;
    logic signed [COORD_W+1:0] tx, ty, stepS;

    // Target cell of the current direction/step, signed so the low edge is detectable
    assign stepS = (COORD_W + 2)'(step);
    assign tx = $signed({2'b00, cx}) + (dir == 2'd0 ? stepS : dir == 2'd1 ? -stepS : '0);
    assign ty = $signed({2'b00, cy}) + (dir == 2'd2 ? stepS : dir == 2'd3 ? -stepS : '0);
    assign inGrid = !tx[COORD_W+1] && tx < GRID_S && !ty[COORD_W+1] && ty < GRID_S;

    assign place_ready = state == IDLE && freeAvail && !pending && !bomb_tick;
    assign accept = place_valid && place_ready;
    assign allocEn = accept && !occMatch;

    // Only in-grid addresses ever leave the block; rdX/rdY hold the address through EVAL
    assign arena_rd_x = state == RD && inGrid ? tx[COORD_W-1:0] : rdX;
    assign arena_rd_y = state == RD && inGrid ? ty[COORD_W-1:0] : rdY;

    assign arena_wr_en = allocEn || state == FREE || (state == EVAL && arena_rd_data == SOFT);
    assign arena_wr_x = state == IDLE ? place_x : state == FREE ? cx : rdX;
    assign arena_wr_y = state == IDLE ? place_y : state == FREE ? cy : rdY;
    assign arena_wr_data = state == IDLE ? BOMB : EMPTY;

    assign chkX = state == CENTER ? cx : rdX;
    assign chkY = state == CENTER ? cy : rdY;
    assign hitNowA = pos_a_x == chkX && pos_a_y == chkY;
    assign hitNowB = pos_b_x == chkX && pos_b_y == chkY;

    assign busy = state != IDLE;
    assign game_over = health_a == 2'd0 || health_b == 2'd0;

    bomb_slots #(.MAX_BOMBS(MAX_BOMBS), .FUSE(FUSE)) slots (
        .clk(clk),
        .rst(rst),
        .allocEn(allocEn),
        .decAll(state == DECR),
        .forceEn(state == EVAL && arena_rd_data == BOMB),
        .freeEn(state == FREE),
        .freeIdx(selIdx),
        .matchX(state == EVAL ? rdX : place_x),
        .matchY(state == EVAL ? rdY : place_y),
        .expIdx(expIdx),
        .anyExp(anyExp),
        .freeAvail(freeAvail),
        .occMatch(occMatch),
        .expX(expX),
        .expY(expY)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            pending <= 1'b0;
            hitA <= 1'b0;
            hitB <= 1'b0;
            dir <= '0;
            step <= '0;
            selIdx <= '0;
            cx <= '0;
            cy <= '0;
            rdX <= '0;
            rdY <= '0;
            health_a <= 2'(HEALTH_INIT);
            health_b <= 2'(HEALTH_INIT);
        end else begin
            if (bomb_tick && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: if (bomb_tick || pending) begin
                    pending <= 1'b0;
                    state <= DECR;
                end
                DECR: state <= SELECT;
                SELECT: if (anyExp) begin
                    selIdx <= expIdx;
                    cx <= expX;
                    cy <= expY;
                    state <= CENTER;
                end else state <= DAMAGE;
                CENTER: begin
                    hitA <= hitA | hitNowA;
                    hitB <= hitB | hitNowB;
                    dir <= '0;
                    step <= SW'(1);
                    state <= RD;
                end
                RD: if (inGrid) begin
                    rdX <= tx[COORD_W-1:0];
                    rdY <= ty[COORD_W-1:0];
                    state <= EVAL;
                end else if (dir == 2'd3) state <= FREE;
                else begin
                    dir <= dir + 2'd1;
                    step <= SW'(1);
                end
                EVAL: begin
                    if (arena_rd_data == BOMB || arena_rd_data == EMPTY) begin
                        hitA <= hitA | hitNowA;
                        hitB <= hitB | hitNowB;
                    end
                    if (arena_rd_data == EMPTY && step != RANGE_S) begin
                        step <= step + 1'b1;
                        state <= RD;
                    end else if (dir == 2'd3) state <= FREE;
                    else begin
                        dir <= dir + 2'd1;
                        step <= SW'(1);
                        state <= RD;
                    end
                end
                FREE: state <= SELECT;
                DAMAGE: begin
                    health_a <= hitA && health_a != 2'd0 ? health_a - 2'd1 : health_a;
                    health_b <= hitB && health_b != 2'd0 ? health_b - 2'd1 : health_b;
                    hitA <= 1'b0;
                    hitB <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/blast_engine.md
# blast_engine

Owns every live bomb in the arena: takes placement requests from the movement stage, counts each fuse down on the 1 Hz bomb tick, and resolves expired bombs. Resolution walks a cross-shaped blast over the arena map, clears soft walls, chain-detonates other bombs and decrements player health. Sits directly downstream of movement/input handling. Owns the arena write port and feeds health to the seven-segment display stage.

## Interface
Parameters:
- GRID, 10: arena side length; coordinates 0..GRID-1.
- MAX_BOMBS, 4: bomb slot count.
- FUSE, 3: ticks from placement to detonation.
- RANGE, 2: blast reach in cells from the centre, per direction.
- HEALTH_INIT, 1: health of each player at reset.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- bomb_tick, in, 1: one-cycle 1 Hz enable, synchronous to clk.
- place_valid, in, 1: bomb placement request.
- place_x, place_y, in, 4 each: placement cell.
- place_ready, out, 1: request accepted in any cycle where place_valid && place_ready.
- pos_a_x, pos_a_y, pos_b_x, pos_b_y, in, 4 each: current player cells.
- arena_rd_x, arena_rd_y, out, 4 each: arena read address.
- arena_rd_data, in, 2: read data, returned 1 cycle after the address.
- arena_wr_en, out, 1: arena write strobe.
- arena_wr_x, arena_wr_y, out, 4 each: write address.
- arena_wr_data, out, 2: write data.
- health_a, health_b, out, 2 each: player health.
- game_over, out, 1: high while either health is 0.
- busy, out, 1: high whenever the FSM is not IDLE.

## Operation
- Arena codes: 0 empty, 1 hard wall, 2 soft wall, 3 bomb.
- Slot table: per slot, valid bit, x, y and fuse counter (width clog2(FUSE+1)). A slot is expired when valid and fuse==0.
- FSM states: IDLE, DECR, SELECT, CENTER, RD, EVAL, FREE, DAMAGE.
- IDLE:
  - A pending tick (bomb_tick, or a tick latched earlier) goes to DECR.
  - Otherwise placement is serviced.
  - place_ready=1 only in IDLE, with a free slot and no pending tick.
  - On accept: allocate the lowest free slot, fuse=FUSE, write code 3 at (place_x, place_y) in the same cycle.
  - The movement stage guarantees the target cell is empty. A placement on a cell already holding a live bomb is ignored, but still handshaken.
- DECR: every valid slot with fuse>0 decrements by 1, then go to SELECT.
- SELECT:
  - Lowest-index expired slot goes to CENTER.
  - No expired slot goes to DAMAGE.
- CENTER: compare the centre cell against both player positions and set hit_a/hit_b. Then scan directions in order +x, -x, +y, -y, at step 1.
- RD: if the target cell is outside 0..GRID-1, the direction ends. Otherwise issue the read.
- EVAL, on arena_rd_data:
  - Hard wall: direction ends.
  - Soft wall: write 0, direction ends. The cell is not a player-hit cell.
  - Bomb: any live slot at that cell has its fuse forced to 0; direction ends. The cell is a player-hit cell.
  - Empty: player-hit check, then the next step. After step RANGE the direction ends.
  - When the last direction ends, go to FREE.
- FREE: write 0 at the centre, clear the slot's valid bit, return to SELECT. Chained bombs are therefore resolved within the same sweep.
- DAMAGE: each of health_a/health_b decrements by 1 if its hit flag is set, saturating at 0. A player loses at most 1 health per sweep. Clear the hit flags, go to IDLE.
- A bomb_tick arriving while not IDLE sets a pending flag; at most one tick is queued and further ticks are dropped.
- Player positions are sampled during the sweep. A player moving mid-sweep is checked at whatever position is current in that cycle.

## Timing
- Reset values: health_a = health_b = HEALTH_INIT; all slots invalid; FSM in IDLE; pending clear.
- Reset outputs: place_ready = 1; arena_wr_en = 0; busy = 0; game_over = 0 (1 if HEALTH_INIT = 0).
- Reset mid-sweep abandons the sweep. Arena contents are not repaired; the arena owner resets in parallel.
- Placement: the arena write happens in the accept cycle. The fuse expires on the FUSE-th subsequent tick.
- Sweep cost per bomb: 1 (CENTER) + 2 per in-grid cell examined + 1 (FREE).
- Worst case per tick: 1 (DECR) + MAX_BOMBS x (8·RANGE + 2) + MAX_BOMBS + 2 (SELECT/DAMAGE) cycles, far below one tick period.
- Health updates become visible the cycle after DAMAGE.
- arena_rd_* is held stable in the EVAL cycle.

## Structure
- Shared package bomberman_pkg: arena code constants (EMPTY, HARD, SOFT, BOMB), the coordinate width constant and the FSM state enum.
- One natural sub-module: bomb_slots, the slot table.
  - Inputs: allocate, decrement-all, force-expire-by-coordinate and free.
  - Outputs: lowest-expired index, free-slot-available and occupancy match.

## Test plan
- Place at (4,4), FUSE=3, empty surroundings -> arena(4,4)=3 after accept; on the 3rd tick arena(4,4)=0, no other writes, health unchanged.
- Soft wall at (5,4) and (6,4), bomb at (4,4) -> only (5,4) cleared; (6,4) stays 2.
- Hard wall at (3,4) and player A at (2,4) -> health_a unchanged. Player A at (4,6) -> health_a 1→0, game_over=1.
- Bombs at (1,1) and (1,3): second placed 2 ticks later -> both cleared in the same sweep, both slots freed.
- Bomb at (0,0) -> no reads outside the grid; only +x and +y cells examined.
- Fill all MAX_BOMBS slots -> place_ready=0. A tick asserted mid-sweep -> exactly one extra DECR after the return to IDLE.
